// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: selects register-file operands with same-cycle
// writeback bypass, detects load-use hazards, and holds the EX-stage register.
module id_ex_operand_stage #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_id_valid,
    input  logic [XLEN-1:0]   i_id_pc,
    input  logic [4:0]        i_id_rs1_addr,
    input  logic [4:0]        i_id_rs2_addr,
    input  logic              i_id_use_rs1,
    input  logic              i_id_use_rs2,
    input  logic [4:0]        i_id_rd_addr,
    input  logic              i_id_rd_wren,
    input  logic              i_id_is_load,
    input  logic [XLEN-1:0]   i_id_imm,
    input  logic [CTRL_W-1:0] i_id_ctrl,
    input  logic [XLEN-1:0]   i_rs1_data,
    input  logic [XLEN-1:0]   i_rs2_data,
    input  logic [4:0]        i_wb_rd_addr,
    input  logic              i_wb_rd_wren,
    input  logic [XLEN-1:0]   i_wb_rd_data,
    input  logic              i_flush,
    input  logic              i_ex_stall,
    output logic              o_id_stall,
    output logic              o_ex_valid,
    output logic [XLEN-1:0]   o_ex_pc,
    output logic [XLEN-1:0]   o_ex_rs1_data,
    output logic [XLEN-1:0]   o_ex_rs2_data,
    output logic [4:0]        o_ex_rs1_addr,
    output logic [4:0]        o_ex_rs2_addr,
    output logic [4:0]        o_ex_rd_addr,
    output logic              o_ex_rd_wren,
    output logic              o_ex_is_load,
    output logic [XLEN-1:0]   o_ex_imm,
    output logic [CTRL_W-1:0] o_ex_ctrl,
    output logic [31:0]       o_lu_bubble_cnt
);

    logic              r_ex_valid;
    logic [XLEN-1:0]   r_ex_pc;
    logic [XLEN-1:0]   r_ex_rs1_data;
    logic [XLEN-1:0]   r_ex_rs2_data;
    logic [4:0]        r_ex_rs1_addr;
    logic [4:0]        r_ex_rs2_addr;
    logic [4:0]        r_ex_rd_addr;
    logic              r_ex_rd_wren;
    logic              r_ex_is_load;
    logic [XLEN-1:0]   r_ex_imm;
    logic [CTRL_W-1:0] r_ex_ctrl;
    logic [31:0]       r_lu_bubble_cnt;

    logic [XLEN-1:0]   w_rs1_sel;
    logic [XLEN-1:0]   w_rs2_sel;
    logic              w_lu;

    // Operand select: x0 reads as zero, otherwise bypass a same-cycle WB write
    always_comb begin
        w_rs1_sel = i_rs1_data;
        w_rs2_sel = i_rs2_data;
        if (i_id_rs1_addr == 5'd0) begin
            w_rs1_sel = '0;
        end else if (i_wb_rd_wren && (i_wb_rd_addr == i_id_rs1_addr)) begin
            w_rs1_sel = i_wb_rd_data;
        end
        if (i_id_rs2_addr == 5'd0) begin
            w_rs2_sel = '0;
        end else if (i_wb_rd_wren && (i_wb_rd_addr == i_id_rs2_addr)) begin
            w_rs2_sel = i_wb_rd_data;
        end
    end

    // Load-use hazard against the load currently in EX, and the IF/ID hold
    always_comb begin
        w_lu = r_ex_valid && r_ex_is_load && r_ex_rd_wren && (r_ex_rd_addr != 5'd0) &&
               i_id_valid &&
               ((i_id_use_rs1 && (i_id_rs1_addr == r_ex_rd_addr)) ||
                (i_id_use_rs2 && (i_id_rs2_addr == r_ex_rd_addr)));
        o_id_stall = (w_lu || i_ex_stall) && !i_flush;
    end

    // EX register: flush > downstream stall > load-use bubble > load
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ex_valid      <= 1'b0;
            r_ex_pc         <= '0;
            r_ex_rs1_data   <= '0;
            r_ex_rs2_data   <= '0;
            r_ex_rs1_addr   <= '0;
            r_ex_rs2_addr   <= '0;
            r_ex_rd_addr    <= '0;
            r_ex_rd_wren    <= 1'b0;
            r_ex_is_load    <= 1'b0;
            r_ex_imm        <= '0;
            r_ex_ctrl       <= '0;
            r_lu_bubble_cnt <= '0;
        end else if (i_flush) begin
            r_ex_valid <= 1'b0;
        end else if (i_ex_stall) begin
            r_ex_valid <= r_ex_valid;
        end else if (w_lu) begin
            r_ex_valid      <= 1'b0;
            r_ex_rd_wren    <= 1'b0;
            r_ex_is_load    <= 1'b0;
            r_lu_bubble_cnt <= r_lu_bubble_cnt + 32'd1;
        end else begin
            r_ex_valid    <= i_id_valid;
            r_ex_pc       <= i_id_pc;
            r_ex_rs1_data <= w_rs1_sel;
            r_ex_rs2_data <= w_rs2_sel;
            r_ex_rs1_addr <= i_id_rs1_addr;
            r_ex_rs2_addr <= i_id_rs2_addr;
            r_ex_rd_addr  <= i_id_rd_addr;
            r_ex_rd_wren  <= i_id_rd_wren;
            r_ex_is_load  <= i_id_is_load;
            r_ex_imm      <= i_id_imm;
            r_ex_ctrl     <= i_id_ctrl;
        end
    end

    assign o_ex_valid      = r_ex_valid;
    assign o_ex_pc         = r_ex_pc;
    assign o_ex_rs1_data   = r_ex_rs1_data;
    assign o_ex_rs2_data   = r_ex_rs2_data;
    assign o_ex_rs1_addr   = r_ex_rs1_addr;
    assign o_ex_rs2_addr   = r_ex_rs2_addr;
    assign o_ex_rd_addr    = r_ex_rd_addr;
    assign o_ex_rd_wren    = r_ex_rd_wren;
    assign o_ex_is_load    = r_ex_is_load;
    assign o_ex_imm        = r_ex_imm;
    assign o_ex_ctrl       = r_ex_ctrl;
    assign o_lu_bubble_cnt = r_lu_bubble_cnt;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage: a model register file and EX
// snapshot predict each cycle's result; a monitor compares after every edge.
module tb_id_ex_operand_stage;

    localparam int XLEN   = 32;
    localparam int CTRL_W = 16;

    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   rs1d;
        logic [XLEN-1:0]   rs2d;
        logic [4:0]        rs1a;
        logic [4:0]        rs2a;
        logic [4:0]        rd;
        logic              wren;
        logic              load;
        logic [XLEN-1:0]   imm;
        logic [CTRL_W-1:0] ctrl;
        logic [31:0]       cnt;
    } ex_t;

    logic              i_clk = 1'b0;
    logic              i_reset;
    logic              i_id_valid;
    logic [XLEN-1:0]   i_id_pc;
    logic [4:0]        i_id_rs1_addr;
    logic [4:0]        i_id_rs2_addr;
    logic              i_id_use_rs1;
    logic              i_id_use_rs2;
    logic [4:0]        i_id_rd_addr;
    logic              i_id_rd_wren;
    logic              i_id_is_load;
    logic [XLEN-1:0]   i_id_imm;
    logic [CTRL_W-1:0] i_id_ctrl;
    logic [XLEN-1:0]   i_rs1_data;
    logic [XLEN-1:0]   i_rs2_data;
    logic [4:0]        i_wb_rd_addr;
    logic              i_wb_rd_wren;
    logic [XLEN-1:0]   i_wb_rd_data;
    logic              i_flush;
    logic              i_ex_stall;
    logic              o_id_stall;
    logic              o_ex_valid;
    logic [XLEN-1:0]   o_ex_pc;
    logic [XLEN-1:0]   o_ex_rs1_data;
    logic [XLEN-1:0]   o_ex_rs2_data;
    logic [4:0]        o_ex_rs1_addr;
    logic [4:0]        o_ex_rs2_addr;
    logic [4:0]        o_ex_rd_addr;
    logic              o_ex_rd_wren;
    logic              o_ex_is_load;
    logic [XLEN-1:0]   o_ex_imm;
    logic [CTRL_W-1:0] o_ex_ctrl;
    logic [31:0]       o_lu_bubble_cnt;

    id_ex_operand_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_id_valid(i_id_valid), .i_id_pc(i_id_pc),
        .i_id_rs1_addr(i_id_rs1_addr), .i_id_rs2_addr(i_id_rs2_addr),
        .i_id_use_rs1(i_id_use_rs1), .i_id_use_rs2(i_id_use_rs2),
        .i_id_rd_addr(i_id_rd_addr), .i_id_rd_wren(i_id_rd_wren),
        .i_id_is_load(i_id_is_load), .i_id_imm(i_id_imm), .i_id_ctrl(i_id_ctrl),
        .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data),
        .i_wb_rd_addr(i_wb_rd_addr), .i_wb_rd_wren(i_wb_rd_wren),
        .i_wb_rd_data(i_wb_rd_data), .i_flush(i_flush), .i_ex_stall(i_ex_stall),
        .o_id_stall(o_id_stall), .o_ex_valid(o_ex_valid), .o_ex_pc(o_ex_pc),
        .o_ex_rs1_data(o_ex_rs1_data), .o_ex_rs2_data(o_ex_rs2_data),
        .o_ex_rs1_addr(o_ex_rs1_addr), .o_ex_rs2_addr(o_ex_rs2_addr),
        .o_ex_rd_addr(o_ex_rd_addr), .o_ex_rd_wren(o_ex_rd_wren),
        .o_ex_is_load(o_ex_is_load), .o_ex_imm(o_ex_imm), .o_ex_ctrl(o_ex_ctrl),
        .o_lu_bubble_cnt(o_lu_bubble_cnt)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;
    ex_t sbq[$];
    ex_t m;                      // model of the EX register contents
    logic [XLEN-1:0] rf[32];     // model register file (rf[0] is raw garbage)

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural value a consumer should see: x0 is zero, a WB this cycle wins
    function automatic logic [XLEN-1:0] arch_val(input logic [4:0] a);
        if (a == 5'd0) return '0;
        if (i_wb_rd_wren && i_wb_rd_addr == a) return i_wb_rd_data;
        return rf[a];
    endfunction

    task automatic idle();
        i_id_valid = 0; i_id_pc = '0; i_id_rs1_addr = 0; i_id_rs2_addr = 0;
        i_id_use_rs1 = 0; i_id_use_rs2 = 0; i_id_rd_addr = 0; i_id_rd_wren = 0;
        i_id_is_load = 0; i_id_imm = '0; i_id_ctrl = '0;
        i_wb_rd_addr = 0; i_wb_rd_wren = 0; i_wb_rd_data = '0;
        i_flush = 0; i_ex_stall = 0;
    endtask

    task automatic set_instr(input logic [XLEN-1:0] pc, input logic [4:0] rs1, input logic u1,
                             input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                             input logic ld);
        i_id_valid = 1; i_id_pc = pc; i_id_rs1_addr = rs1; i_id_use_rs1 = u1;
        i_id_rs2_addr = rs2; i_id_use_rs2 = u2; i_id_rd_addr = rd; i_id_rd_wren = 1;
        i_id_is_load = ld; i_id_imm = $urandom; i_id_ctrl = CTRL_W'($urandom);
    endtask

    // One cycle: inputs already set at the falling edge; predict, push, clock.
    task automatic step();
        logic consumer_needs_load;
        logic exp_stall;
        ex_t nx;
        i_rs1_data = rf[i_id_rs1_addr];
        i_rs2_data = rf[i_id_rs2_addr];
        #1;
        consumer_needs_load = m.valid && m.load && m.wren && m.rd != 0 && i_id_valid &&
                              ((i_id_use_rs1 && i_id_rs1_addr == m.rd) ||
                               (i_id_use_rs2 && i_id_rs2_addr == m.rd));
        exp_stall = (consumer_needs_load || i_ex_stall) && !i_flush;
        check("id_stall", 64'(o_id_stall), 64'(exp_stall));
        nx = m;
        if (i_flush) begin
            nx.valid = 0;
        end else if (i_ex_stall) begin
            nx = m;
        end else if (consumer_needs_load) begin
            nx.valid = 0; nx.wren = 0; nx.load = 0; nx.cnt = m.cnt + 1;
        end else begin
            nx.valid = i_id_valid;  nx.pc = i_id_pc;
            nx.rs1d = arch_val(i_id_rs1_addr); nx.rs2d = arch_val(i_id_rs2_addr);
            nx.rs1a = i_id_rs1_addr; nx.rs2a = i_id_rs2_addr; nx.rd = i_id_rd_addr;
            nx.wren = i_id_rd_wren; nx.load = i_id_is_load;
            nx.imm = i_id_imm; nx.ctrl = i_id_ctrl;
        end
        sbq.push_back(nx);
        m = nx;
        @(posedge i_clk);
        if (i_wb_rd_wren && i_wb_rd_addr != 0) rf[i_wb_rd_addr] = i_wb_rd_data;
        @(negedge i_clk);
    endtask

    // Monitor: compare the registered EX state against the scoreboard after each edge
    always @(posedge i_clk) begin
        ex_t e;
        #1;
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            check("ex_valid", 64'(o_ex_valid), 64'(e.valid));
            check("bubble_cnt", 64'(o_lu_bubble_cnt), 64'(e.cnt));
            if (e.valid) begin
                check("ex_pc", 64'(o_ex_pc), 64'(e.pc));
                check("ex_rs1_data", 64'(o_ex_rs1_data), 64'(e.rs1d));
                check("ex_rs2_data", 64'(o_ex_rs2_data), 64'(e.rs2d));
                check("ex_rs1_addr", 64'(o_ex_rs1_addr), 64'(e.rs1a));
                check("ex_rs2_addr", 64'(o_ex_rs2_addr), 64'(e.rs2a));
                check("ex_rd_addr", 64'(o_ex_rd_addr), 64'(e.rd));
                check("ex_rd_wren", 64'(o_ex_rd_wren), 64'(e.wren));
                check("ex_is_load", 64'(o_ex_is_load), 64'(e.load));
                check("ex_imm", 64'(o_ex_imm), 64'(e.imm));
                check("ex_ctrl", 64'(o_ex_ctrl), 64'(e.ctrl));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        rf[0] = 32'h5A5A5A5A;
        idle();
        i_rs1_data = '0; i_rs2_data = '0;
        i_reset = 1;
        m = '0;
        repeat (2) @(negedge i_clk);
        check("rst_valid", 64'(o_ex_valid), 64'd0);
        check("rst_pc", 64'(o_ex_pc), 64'd0);
        check("rst_rs1_data", 64'(o_ex_rs1_data), 64'd0);
        check("rst_ctrl", 64'(o_ex_ctrl), 64'd0);
        check("rst_cnt", 64'(o_lu_bubble_cnt), 64'd0);
        check("rst_id_stall", 64'(o_id_stall), 64'd0);
        i_reset = 0;

        // Same-cycle writeback bypass
        rf[5] = 32'h11111111;
        idle(); set_instr(32'h40, 5'd5, 1, 5'd0, 0, 5'd9, 0);
        i_wb_rd_addr = 5; i_wb_rd_wren = 1; i_wb_rd_data = 32'hCAFEBABE;
        step();
        check("bypass_rs1", 64'(o_ex_rs1_data), 64'h0CAFEBABE);

        // x0 never forwarded
        idle(); set_instr(32'h44, 5'd0, 1, 5'd0, 1, 5'd9, 0);
        i_wb_rd_addr = 0; i_wb_rd_wren = 1; i_wb_rd_data = 32'hDEADBEEF;
        step();
        check("x0_rs1", 64'(o_ex_rs1_data), 64'd0);
        check("x0_rs2", 64'(o_ex_rs2_data), 64'd0);

        // Load-use: lw x7 then add using x7 as rs2
        idle(); set_instr(32'h200, 5'd1, 1, 5'd0, 0, 5'd7, 1); step();
        idle(); set_instr(32'h204, 5'd3, 1, 5'd7, 1, 5'd8, 0); step();
        check("lu_bubble_valid", 64'(o_ex_valid), 64'd0);
        check("lu_cnt_1", 64'(o_lu_bubble_cnt), 64'd1);
        step();
        check("lu_after_valid", 64'(o_ex_valid), 64'd1);
        check("lu_after_pc", 64'(o_ex_pc), 64'h204);
        idle(); set_instr(32'h208, 5'd1, 1, 5'd0, 0, 5'd7, 1); step();
        idle(); set_instr(32'h20C, 5'd3, 1, 5'd7, 0, 5'd8, 0); step();
        check("no_use_valid", 64'(o_ex_valid), 64'd1);
        check("no_use_cnt", 64'(o_lu_bubble_cnt), 64'd1);

        // Flush beats stall and load-use
        idle(); set_instr(32'h300, 5'd1, 1, 5'd0, 0, 5'd7, 1); step();
        idle(); set_instr(32'h304, 5'd7, 1, 5'd2, 1, 5'd8, 0);
        i_ex_stall = 1; i_flush = 1; step();
        check("flush_valid", 64'(o_ex_valid), 64'd0);
        check("flush_cnt", 64'(o_lu_bubble_cnt), 64'd1);

        // Downstream stall holds pc 0x100 for three cycles
        idle(); set_instr(32'h100, 5'd1, 1, 5'd2, 1, 5'd3, 0); step();
        for (int k = 0; k < 3; k++) begin
            idle(); set_instr(32'h104, 5'd2, 1, 5'd3, 1, 5'd4, 0);
            i_ex_stall = 1; step();
            check("stall_pc_hold", 64'(o_ex_pc), 64'h100);
        end
        i_ex_stall = 0; step();
        check("stall_release_pc", 64'(o_ex_pc), 64'h104);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            i_id_valid    = ($urandom % 4) != 0;
            i_id_pc       = $urandom;
            i_id_rs1_addr = 5'($urandom_range(0, 3));
            i_id_rs2_addr = 5'($urandom_range(0, 3));
            i_id_use_rs1  = 1'($urandom);
            i_id_use_rs2  = 1'($urandom);
            i_id_rd_addr  = 5'($urandom_range(0, 3));
            i_id_rd_wren  = ($urandom % 4) != 0;
            i_id_is_load  = 1'($urandom);
            i_id_imm      = $urandom;
            i_id_ctrl     = CTRL_W'($urandom);
            i_wb_rd_addr  = 5'($urandom_range(0, 3));
            i_wb_rd_wren  = 1'($urandom);
            i_wb_rd_data  = $urandom;
            i_flush       = ($urandom % 16) == 0;
            i_ex_stall    = ($urandom % 6) == 0;
            step();

            // Asynchronous reset between edges, once, mid-stream
            if (n == 700) begin
                idle(); set_instr(32'h500, 5'd1, 1, 5'd2, 1, 5'd3, 0); step();
                check("pre_reset_valid", 64'(o_ex_valid), 64'd1);
                #2 i_reset = 1;
                #1;
                check("async_rst_valid", 64'(o_ex_valid), 64'd0);
                check("async_rst_cnt", 64'(o_lu_bubble_cnt), 64'd0);
                m = '0;
                #1 i_reset = 0;
                @(negedge i_clk);
                idle(); set_instr(32'h600, 5'd2, 1, 5'd1, 1, 5'd3, 0); step();
                check("post_reset_pc", 64'(o_ex_pc), 64'h600);
            end
        end

        idle();
        repeat (2) @(negedge i_clk);
        check("scoreboard_drained", 64'(sbq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline stage directly downstream of `regfile`.
- Captures the decoded instruction and both register-file read operands into the EX-stage register.
- Bypasses a same-cycle writeback, since `regfile` returns the old value while it is being written.
- Detects load-use hazards and inserts one bubble; honours downstream stall and branch-mispredict flush from the 2-bit predictor path.

Parameters:
- `XLEN`, 32, datapath/operand width.
- `CTRL_W`, 16, width of the opaque decoded-control bundle passed through to EX.

Ports:
- `i_clk`  in  1  clock, all state updates on rising edge.
- `i_reset`  in  1  asynchronous, active-high reset.
- `i_id_valid`  in  1  ID holds a valid instruction.
- `i_id_pc`  in  XLEN  instruction PC.
- `i_id_rs1_addr`  in  5  source 1 index; also drives `regfile` `i_rs1_addr`.
- `i_id_rs2_addr`  in  5  source 2 index; also drives `regfile` `i_rs2_addr`.
- `i_id_use_rs1`  in  1  instruction actually reads rs1.
- `i_id_use_rs2`  in  1  instruction actually reads rs2.
- `i_id_rd_addr`  in  5  destination index.
- `i_id_rd_wren`  in  1  instruction writes rd.
- `i_id_is_load`  in  1  instruction is a load.
- `i_id_imm`  in  XLEN  decoded immediate.
- `i_id_ctrl`  in  CTRL_W  decoded control bundle.
- `i_rs1_data`  in  XLEN  `regfile` `o_rs1_data`.
- `i_rs2_data`  in  XLEN  `regfile` `o_rs2_data`.
- `i_wb_rd_addr`  in  5  writeback index (same signal as `regfile` `i_rd_addr`).
- `i_wb_rd_wren`  in  1  writeback enable.
- `i_wb_rd_data`  in  XLEN  writeback data.
- `i_flush`  in  1  mispredict flush of ID/EX.
- `i_ex_stall`  in  1  EX cannot accept; hold the register.
- `o_id_stall`  out  1  IF/ID must hold (combinational).
- `o_ex_valid`  out  1  EX-register valid.
- `o_ex_pc`  out  XLEN  registered PC.
- `o_ex_rs1_data`  out  XLEN  registered operand 1.
- `o_ex_rs2_data`  out  XLEN  registered operand 2.
- `o_ex_rs1_addr`  out  5  registered rs1 index, for EX forwarding.
- `o_ex_rs2_addr`  out  5  registered rs2 index, for EX forwarding.
- `o_ex_rd_addr`  out  5  registered rd index.
- `o_ex_rd_wren`  out  1  registered rd write enable.
- `o_ex_is_load`  out  1  registered load flag.
- `o_ex_imm`  out  XLEN  registered immediate.
- `o_ex_ctrl`  out  CTRL_W  registered control bundle.
- `o_lu_bubble_cnt`  out  32  count of load-use bubbles inserted.

Behaviour:
- Reset:
  - Applies asynchronously on `i_reset`=1.
  - All `o_ex_*` go to 0, `o_lu_bubble_cnt` goes to 0.
  - `o_id_stall` then evaluates combinationally to 0, because `o_ex_valid`=0.
  - Reset mid-operation discards the EX contents; no bubble is counted.
- Operand select, combinational, per source s ∈ {1,2}:
  - `rs_addr`==0 → 0, regardless of `i_rs*_data` and any WB write to x0.
  - Else if `i_wb_rd_wren` && `i_wb_rd_addr`==`rs_addr` → `i_wb_rd_data`.
  - Else → `i_rs*_data`.
- Load-use hazard, combinational:
  - `lu` = `o_ex_valid` && `o_ex_is_load` && `o_ex_rd_wren` && `o_ex_rd_addr`!=0 && `i_id_valid` && ((`i_id_use_rs1` && `i_id_rs1_addr`==`o_ex_rd_addr`) || (`i_id_use_rs2` && `i_id_rs2_addr`==`o_ex_rd_addr`)).
- `o_id_stall` = (`lu` || `i_ex_stall`) && !`i_flush`.
- Register update on each rising edge, highest priority first:
  1. `i_flush`: `o_ex_valid`←0; other fields don't-care (hold). Overrides `i_ex_stall` and `lu`.
  2. `i_ex_stall`: all `o_ex_*` hold. No bubble inserted, counter unchanged, even if `lu`=1.
  3. `lu`: bubble, i.e. `o_ex_valid`←0, `o_ex_rd_wren`←0, `o_ex_is_load`←0. `o_lu_bubble_cnt`+1, wrapping 0xFFFFFFFF→0.
  4. Otherwise load: `o_ex_valid`←`i_id_valid`; all other fields ← ID inputs and selected operands.
- Hazard duration: a load-use stall lasts exactly 1 cycle. After the bubble, `o_ex_valid`=0, so `lu` clears, and the load has moved to MEM, where the EX forwarding unit resolves it.
- Latency: 1 cycle ID→EX with no hazard.
- While IF/ID is held, operands are re-selected every cycle, so a WB write during the hold is picked up.
- x0: never triggers `lu`; never forwarded.

Test Plan:
- Bypass: x5=0x11111111 in `regfile`; WB writes x5=0xCAFEBABE in the same cycle ID reads x5 → next cycle `o_ex_rs1_data`=0xCAFEBABE, `o_id_stall`=0.
- x0: ID reads rs1=rs2=x0 while WB writes x0=0xDEADBEEF → `o_ex_rs1_data`=`o_ex_rs2_data`=0.
- Load-use: `lw` x7 in EX, then `add` using x7 as rs2 in ID → `o_id_stall`=1 for 1 cycle; EX bubble (`o_ex_valid`=0); `o_lu_bubble_cnt`=1; `add` enters EX the following cycle. Repeat with `i_id_use_rs2`=0 → no stall.
- Flush precedence: `i_flush`=1 with `i_ex_stall`=1 and `lu`=1 → `o_ex_valid`=0 next edge, `o_id_stall`=0, counter unchanged.
- Downstream stall: `i_ex_stall`=1 for 3 cycles with pc 0x100 in EX → `o_ex_pc` stays 0x100, `o_id_stall`=1 throughout; release → next ID instruction loads.
- Async reset mid-stream: assert `i_reset` between clock edges with `o_ex_valid`=1 → `o_ex_valid`=0 and counter=0 immediately; pipeline resumes after deassert.
